sum_reduce_sched: RTL and testbench
===================================

// Module: sum_reduce_sched
// PURPOSE
//  Sequencer for the shared pairwise-adder reduction array (P adders, P result lanes) that sums N
//  inputs in K cycles. Accepts a start request, then drives per-cycle operand-group select, adder
//  mode, lane enables and tree level. Holds a result-valid/ready handshake until the sum is consumed.
//  Sits beside the adder datapath; owns no arithmetic.
// PARAMETERS
//  N    40  number of input operands; must satisfy N >= 2*P
//  P    8   number of adders/lanes; power of two, >= 2
//  GW   4   width of grp_sel; must hold L-1 (see BEHAVIOUR)
//  LW   2   width of tree_lvl; must hold log2(P)-1, minimum 1
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    asynchronous, active-low reset
//  start      in   1    request a new reduction; accepted only when in_ready=1
//  abort      in   1    synchronous cancel; priority over start
//  in_ready   out  1    1 only in IDLE
//  busy       out  1    1 in LOAD, ACCUM and REDUCE
//  op_mode    out  2    00 hold, 01 load pair, 10 accumulate, 11 tree reduce
//  grp_sel    out  GW   operand group index for the current load/accumulate cycle
//  lane_en    out  P    per-lane write enable for this cycle
//  tree_lvl   out  LW   reduction level during REDUCE, else 0
//  res_valid  out  1    lane 0 holds the final sum
//  res_ready  in   1    consumer accepts the result
// BEHAVIOUR
//  - Counts: L = 1 + ceil((N-2P)/P) load/accumulate cycles; R = log2(P) reduce cycles; K = L+R.
//  - States: IDLE -> LOAD -> ACCUM (skipped if N==2P) -> REDUCE -> DONE -> IDLE.
//  - Reset (rst=0, async): state IDLE. Outputs: in_ready=1; busy=0; op_mode=00; grp_sel=0;
//    lane_en=0; tree_lvl=0; res_valid=0.
//  - Start: start=1 at edge t in IDLE -> LOAD during cycle t+1. start in any other state ignored.
//  - LOAD (1 cycle): op_mode=01, grp_sel=0, lane_en=all ones. Lane i <= num[2i]+num[2i+1]
//    (0-based operand index).
//  - ACCUM, g=1..L-1: op_mode=10, grp_sel=g. Lane i <= lane i + num[2P+(g-1)P+i].
//    lane_en[i]=1 iff 2P+(g-1)P+i < N; partial last group masks the upper lanes.
//  - REDUCE, l=0..R-1: op_mode=11, tree_lvl=l. Lane i <= lane 2i + lane 2i+1.
//    lane_en[i]=1 iff i < P>>(l+1).
//  - After the last REDUCE cycle -> DONE. DONE: res_valid=1, op_mode=00, lane_en=0, in_ready=0.
//    res_valid first asserts in cycle t+1+K.
//  - DONE with res_ready=1 at an edge -> IDLE next cycle. res_valid stays high until that edge.
//  - start is not accepted in the same cycle as the res_ready handshake.
//  - abort=1 at an edge in any non-IDLE state -> IDLE next cycle, no res_valid.
//    abort with start in IDLE: remain IDLE.
//  - grp_sel and tree_lvl counters clear on entering IDLE. Neither counter wraps in normal
//    operation; a terminal count always transitions state.
//  - Async reset mid-operation: all outputs return to reset values immediately; no partial result
//    is flagged.
// TESTING
//  - N=40,P=8: start pulse -> op_mode 01,10,10,10,11,11,11.
//    grp_sel 0,1,2,3; tree_lvl 0,1,2; lane_en FF,FF,FF,FF,0F,03,01; res_valid at cycle t+8.
//  - N=36,P=8: ACCUM g=3 lane_en=8'h0F. Reduce sequence unchanged. K=7.
//  - N=16,P=8: LOAD then directly REDUCE. K=4. No op_mode=10 cycle.
//  - res_ready low for 5 cycles: res_valid stays 1, in_ready stays 0, lane_en=0.
//    res_ready=1 -> IDLE next cycle.
//  - Abort during REDUCE level 1 -> IDLE next cycle, res_valid never asserts.
//    Fresh start then completes in K cycles.
//  - rst=0 asynchronously during ACCUM: outputs go to reset values immediately.
//    start while busy: ignored, sequence unchanged.

Source files
------------

// File: rtl/sum_reduce_sched.sv
// Control sequencer for a shared pairwise-adder reduction array.
// It drives load, accumulate and tree-reduce cycles, then holds the result under a valid/ready handshake.
module sum_reduce_sched #(
   parameter int N  = 40,
   parameter int P  = 8,
   parameter int GW = 4,
   parameter int LW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   output logic          in_ready,
   output logic          busy,
   output logic [1:0]    op_mode,
   output logic [GW-1:0] grp_sel,
   output logic [P-1:0]  lane_en,
   output logic [LW-1:0] tree_lvl,
   output logic          res_valid,
   input  logic          res_ready
);

   localparam int L = 1 + (N - 2*P + P - 1) / P;
   localparam int R = $clog2(P);
   localparam logic [GW-1:0] GRP_LAST = GW'(L - 1);
   localparam logic [LW-1:0] LVL_LAST = LW'(R - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ACCUM,
      S_REDUCE,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [GW-1:0] grp_q, grp_d;
   logic [LW-1:0] lvl_q, lvl_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         grp_q   <= '0;
         lvl_q   <= '0;
      end else begin
         state_q <= state_d;
         grp_q   <= grp_d;
         lvl_q   <= lvl_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grp_d   = grp_q;
      lvl_d   = lvl_q;
      if (state_q != S_IDLE && abort) begin
         state_d = S_IDLE;
         grp_d   = '0;
         lvl_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !abort) state_d = S_LOAD;
            end
            S_LOAD: begin
               // With exactly 2P operands the single load covers everything.
               if (L > 1) begin
                  state_d = S_ACCUM;
                  grp_d   = GW'(1);
               end else begin
                  state_d = S_REDUCE;
                  lvl_d   = '0;
               end
            end
            S_ACCUM: begin
               if (grp_q == GRP_LAST) begin
                  state_d = S_REDUCE;
                  lvl_d   = '0;
               end else begin
                  grp_d = grp_q + 1'b1;
               end
            end
            S_REDUCE: begin
               if (lvl_q == LVL_LAST) state_d = S_DONE;
               else                   lvl_d   = lvl_q + 1'b1;
            end
            S_DONE: begin
               if (res_ready) begin
                  state_d = S_IDLE;
                  grp_d   = '0;
                  lvl_d   = '0;
               end
            end
            default: begin
               state_d = S_IDLE;
               grp_d   = '0;
               lvl_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      in_ready  = 1'b0;
      busy      = 1'b0;
      op_mode   = 2'b00;
      grp_sel   = '0;
      lane_en   = '0;
      tree_lvl  = '0;
      res_valid = 1'b0;
      case (state_q)
         S_IDLE: in_ready = 1'b1;
         S_LOAD: begin
            busy    = 1'b1;
            op_mode = 2'b01;
            lane_en = '1;
         end
         S_ACCUM: begin
            busy    = 1'b1;
            op_mode = 2'b10;
            grp_sel = grp_q;
            // Lanes past the last operand stay idle on a partial final group.
            for (int i = 0; i < P; i++)
               lane_en[i] = (2*P + (int'(grp_q) - 1)*P + i) < N;
         end
         S_REDUCE: begin
            busy     = 1'b1;
            op_mode  = 2'b11;
            tree_lvl = lvl_q;
            for (int i = 0; i < P; i++)
               lane_en[i] = i < (P >> (int'(lvl_q) + 1));
         end
         S_DONE: res_valid = 1'b1;
         default: in_ready = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_sum_reduce_sched.sv
// Scoreboard bench for sum_reduce_sched: three instances (N=40, 36, 16, P=8) with per-instance
// expected-cycle queues popped by monitors whenever an instance is busy or presenting a result.
module tb_sum_reduce_sched;

   localparam int RW = 19;

   logic       clk;
   logic       rst;
   logic [2:0] start_v, abort_v, rr_v;
   logic [2:0] ir_v, bz_v, rv_v;
   logic [1:0] op_v [3];
   logic [3:0] gs_v [3];
   logic [1:0] tl_v [3];
   logic [7:0] le_v [3];

   int errors = 0;
   int checks = 0;

   logic [RW-1:0] q0[$], q1[$], q2[$];
   logic [RW-1:0] tab [3][7];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [RW-1:0] rec(input logic ir, input logic bz, input logic [1:0] op,
                                         input logic [3:0] gs, input logic [1:0] tl,
                                         input logic [7:0] le, input logic rv);
      return {ir, bz, op, gs, tl, le, rv};
   endfunction

   function automatic logic [RW-1:0] cur(input int idx);
      return rec(ir_v[idx], bz_v[idx], op_v[idx], gs_v[idx], tl_v[idx], le_v[idx], rv_v[idx]);
   endfunction

   function automatic int krows(input int idx);
      return (idx == 2) ? 4 : 7;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int idx, input logic [RW-1:0] v);
      case (idx)
         0: q0.push_back(v);
         1: q1.push_back(v);
         default: q2.push_back(v);
      endcase
   endtask

   task automatic mon_check(input int idx, input logic [RW-1:0] act);
      logic [RW-1:0] e;
      logic          have;
      have = 1'b0;
      e    = '0;
      case (idx)
         0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
         1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
         checks++;
         errors++;
         $display("FAIL dut%0d_unexpected: got %h expected no output", idx, act);
      end else begin
         chk($sformatf("dut%0d_cycle", idx), 32'(act), 32'(e));
      end
   endtask

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int NV = (gi == 0) ? 40 : (gi == 1) ? 36 : 16;
      sum_reduce_sched #(.N(NV), .P(8), .GW(4), .LW(2)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .start     (start_v[gi]),
         .abort     (abort_v[gi]),
         .in_ready  (ir_v[gi]),
         .busy      (bz_v[gi]),
         .op_mode   (op_v[gi]),
         .grp_sel   (gs_v[gi]),
         .lane_en   (le_v[gi]),
         .tree_lvl  (tl_v[gi]),
         .res_valid (rv_v[gi]),
         .res_ready (rr_v[gi])
      );

      always @(negedge clk) begin
         if (rst && (bz_v[gi] || rv_v[gi])) mon_check(gi, cur(gi));
      end
   end

   task automatic check_idle(input int idx);
      chk($sformatf("dut%0d_idle", idx), 32'(cur(idx)), 32'(rec(1, 0, 2'd0, 4'd0, 2'd0, 8'h00, 0)));
   endtask

   task automatic run_txn(input int idx, input int nwait, input bit mid_start);
      @(negedge clk);
      start_v[idx] = 1'b1;
      for (int k = 0; k < krows(idx); k++) push_exp(idx, tab[idx][k]);
      for (int k = 0; k <= nwait; k++) push_exp(idx, rec(0, 0, 2'd0, 4'd0, 2'd0, 8'h00, 1));
      @(negedge clk);
      for (int k = 0; k < krows(idx); k++) begin
         start_v[idx] = mid_start && (k == 1);
         @(negedge clk);
      end
      start_v[idx] = 1'b0;
      repeat (nwait) @(negedge clk);
      rr_v[idx] = 1'b1;
      @(negedge clk);
      rr_v[idx] = 1'b0;
      check_idle(idx);
   endtask

   initial begin
      start_v = '0;
      abort_v = '0;
      rr_v    = '0;
      rst     = 1'b1;

      tab[0][0] = rec(0, 1, 2'd1, 4'd0, 2'd0, 8'hFF, 0);
      tab[0][1] = rec(0, 1, 2'd2, 4'd1, 2'd0, 8'hFF, 0);
      tab[0][2] = rec(0, 1, 2'd2, 4'd2, 2'd0, 8'hFF, 0);
      tab[0][3] = rec(0, 1, 2'd2, 4'd3, 2'd0, 8'hFF, 0);
      tab[0][4] = rec(0, 1, 2'd3, 4'd0, 2'd0, 8'h0F, 0);
      tab[0][5] = rec(0, 1, 2'd3, 4'd0, 2'd1, 8'h03, 0);
      tab[0][6] = rec(0, 1, 2'd3, 4'd0, 2'd2, 8'h01, 0);
      tab[1][0] = rec(0, 1, 2'd1, 4'd0, 2'd0, 8'hFF, 0);
      tab[1][1] = rec(0, 1, 2'd2, 4'd1, 2'd0, 8'hFF, 0);
      tab[1][2] = rec(0, 1, 2'd2, 4'd2, 2'd0, 8'hFF, 0);
      tab[1][3] = rec(0, 1, 2'd2, 4'd3, 2'd0, 8'h0F, 0);
      tab[1][4] = rec(0, 1, 2'd3, 4'd0, 2'd0, 8'h0F, 0);
      tab[1][5] = rec(0, 1, 2'd3, 4'd0, 2'd1, 8'h03, 0);
      tab[1][6] = rec(0, 1, 2'd3, 4'd0, 2'd2, 8'h01, 0);
      tab[2][0] = rec(0, 1, 2'd1, 4'd0, 2'd0, 8'hFF, 0);
      tab[2][1] = rec(0, 1, 2'd3, 4'd0, 2'd0, 8'h0F, 0);
      tab[2][2] = rec(0, 1, 2'd3, 4'd0, 2'd1, 8'h03, 0);
      tab[2][3] = rec(0, 1, 2'd3, 4'd0, 2'd2, 8'h01, 0);
      for (int k = 4; k < 7; k++) tab[2][k] = '0;

      #2 rst = 1'b0;
      #5;
      for (int i = 0; i < 3; i++) check_idle(i);
      #16 rst = 1'b1;

      run_txn(0, 0, 1'b1);
      run_txn(1, 0, 1'b0);
      run_txn(2, 0, 1'b0);
      run_txn(0, 5, 1'b0);

      // Abort while reducing at level 1, then a clean run.
      @(negedge clk);
      start_v[0] = 1'b1;
      for (int k = 0; k < 6; k++) push_exp(0, tab[0][k]);
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (5) @(negedge clk);
      abort_v[0] = 1'b1;
      @(negedge clk);
      abort_v[0] = 1'b0;
      check_idle(0);
      repeat (4) @(negedge clk);
      check_idle(0);
      run_txn(0, 0, 1'b0);

      // Asynchronous reset in the middle of ACCUM.
      @(negedge clk);
      start_v[1] = 1'b1;
      for (int k = 0; k < 3; k++) push_exp(1, tab[1][k]);
      @(negedge clk);
      start_v[1] = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check_idle(1);
      @(negedge clk);
      #3 rst = 1'b1;
      @(negedge clk);
      check_idle(1);
      run_txn(1, 0, 1'b0);

      // Abort together with start in IDLE must not launch.
      @(negedge clk);
      start_v[2] = 1'b1;
      abort_v[2] = 1'b1;
      @(negedge clk);
      start_v[2] = 1'b0;
      abort_v[2] = 1'b0;
      check_idle(2);
      repeat (3) @(negedge clk);
      check_idle(2);

      repeat (3) @(negedge clk);
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      chk("q2_drained", 32'(q2.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
